// File: rtl/bbox_scanner.sv
// Raster-scans a WIDTH x HEIGHT pixel memory and reports the bounding box of
// every pixel passing a threshold test, with optional binary mask write-back.
module bbox_scanner #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int PIX_W   = 8,
    parameter int COORD_W = 11,
    parameter int ADDR_W  = 15,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               rdy,
    input  logic [PIX_W-1:0]   threshold,
    input  logic               mode,
    input  logic               mask_en,
    output logic [ADDR_W-1:0]  addr,
    input  logic [PIX_W-1:0]   rddata,
    output logic [ADDR_W-1:0]  mask_addr,
    output logic [7:0]         mask_data,
    output logic               mask_wren,
    output logic [COORD_W-1:0] xMin,
    output logic [COORD_W-1:0] xMax,
    output logic [COORD_W-1:0] yMin,
    output logic [COORD_W-1:0] yMax,
    output logic               found,
    output logic               done
);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(WIDTH - 1);
    localparam logic [2:0]         DRAIN_END = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                           state_q, state_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [COORD_W-1:0]               x_q, x_d, y_q, y_d;
    logic [2:0]                       drain_q, drain_d;
    logic [PIX_W-1:0]                 thr_q, thr_d;
    logic                             mode_q, mode_d, msk_q, msk_d;
    logic [RD_LAT-1:0]                vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][COORD_W-1:0]   px_pipe_q, px_pipe_d, py_pipe_q, py_pipe_d;
    logic [RD_LAT-1:0][ADDR_W-1:0]    pa_pipe_q, pa_pipe_d;
    logic [COORD_W-1:0]               xlo_q, xlo_d, xhi_q, xhi_d, ylo_q, ylo_d, yhi_q, yhi_d;
    logic                             hit_q, hit_d;
    logic [COORD_W-1:0]               xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic                             found_q, found_d, done_q, done_d;
    logic [ADDR_W-1:0]                maddr_q, maddr_d;
    logic [7:0]                       mdata_q, mdata_d;
    logic                             mwren_q, mwren_d;
    logic                             start, out_v, fg;
    logic [COORD_W-1:0]               ox, oy;

    assign rdy   = (state_q == IDLE) || (state_q == DONE);
    assign start = en && rdy;
    assign out_v = vld_pipe_q[RD_LAT-1];
    assign ox    = px_pipe_q[RD_LAT-1];
    assign oy    = py_pipe_q[RD_LAT-1];
    assign fg    = mode_q ? (rddata <= thr_q) : (rddata >= thr_q);

    always_comb begin
        state_d = state_q;  addr_d = addr_q;  x_d = x_q;  y_d = y_q;  drain_d = drain_q;
        thr_d = thr_q;  mode_d = mode_q;  msk_d = msk_q;
        xlo_d = xlo_q;  xhi_d = xhi_q;  ylo_d = ylo_q;  yhi_d = yhi_q;  hit_d = hit_q;
        xmin_d = xmin_q;  xmax_d = xmax_q;  ymin_d = ymin_q;  ymax_d = ymax_q;
        found_d = found_q;  done_d = 1'b0;
        maddr_d = maddr_q;  mdata_d = mdata_q;  mwren_d = 1'b0;

        // Coordinates and address travel with each read so the classifier
        // never has to reconstruct where a returning pixel came from.
        vld_pipe_d   = vld_pipe_q;
        px_pipe_d    = px_pipe_q;
        py_pipe_d    = py_pipe_q;
        pa_pipe_d    = pa_pipe_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            px_pipe_d[i]  = px_pipe_q[i-1];
            py_pipe_d[i]  = py_pipe_q[i-1];
            pa_pipe_d[i]  = pa_pipe_q[i-1];
        end
        vld_pipe_d[0] = (state_q == SCAN);
        px_pipe_d[0]  = x_q;
        py_pipe_d[0]  = y_q;
        pa_pipe_d[0]  = addr_q;

        if (out_v) begin
            if (fg) begin
                hit_d = 1'b1;
                if (ox < xlo_q) xlo_d = ox;
                if (ox > xhi_q) xhi_d = ox;
                if (oy < ylo_q) ylo_d = oy;
                if (oy > yhi_q) yhi_d = oy;
            end
            if (msk_q) begin
                mwren_d = 1'b1;
                maddr_d = pa_pipe_q[RD_LAT-1];
                mdata_d = fg ? 8'hFF : 8'h00;
            end
        end

        case (state_q)
            SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + COORD_W'(1);
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                end
            end
            // The final pixel is classified on the same edge that publishes
            // the results, so the outputs take the next accumulator values.
            DRAIN: begin
                if (drain_q == DRAIN_END) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    found_d = hit_d;
                    xmin_d  = hit_d ? xlo_d : '0;
                    xmax_d  = hit_d ? xhi_d : '0;
                    ymin_d  = hit_d ? ylo_d : '0;
                    ymax_d  = hit_d ? yhi_d : '0;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = SCAN;
            thr_d = threshold;  mode_d = mode;  msk_d = mask_en;
            xlo_d = '1;  ylo_d = '1;  xhi_d = '0;  yhi_d = '0;  hit_d = 1'b0;
            addr_d = '0;  x_d = '0;  y_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;  addr_q <= '0;  x_q <= '0;  y_q <= '0;  drain_q <= '0;
            thr_q <= '0;  mode_q <= 1'b0;  msk_q <= 1'b0;
            vld_pipe_q <= '0;  px_pipe_q <= '0;  py_pipe_q <= '0;  pa_pipe_q <= '0;
            xlo_q <= '1;  xhi_q <= '0;  ylo_q <= '1;  yhi_q <= '0;  hit_q <= 1'b0;
            xmin_q <= '0;  xmax_q <= '0;  ymin_q <= '0;  ymax_q <= '0;
            found_q <= 1'b0;  done_q <= 1'b0;
            maddr_q <= '0;  mdata_q <= '0;  mwren_q <= 1'b0;
        end else begin
            state_q <= state_d;  addr_q <= addr_d;  x_q <= x_d;  y_q <= y_d;  drain_q <= drain_d;
            thr_q <= thr_d;  mode_q <= mode_d;  msk_q <= msk_d;
            vld_pipe_q <= vld_pipe_d;  px_pipe_q <= px_pipe_d;
            py_pipe_q <= py_pipe_d;    pa_pipe_q <= pa_pipe_d;
            xlo_q <= xlo_d;  xhi_q <= xhi_d;  ylo_q <= ylo_d;  yhi_q <= yhi_d;  hit_q <= hit_d;
            xmin_q <= xmin_d;  xmax_q <= xmax_d;  ymin_q <= ymin_d;  ymax_q <= ymax_d;
            found_q <= found_d;  done_q <= done_d;
            maddr_q <= maddr_d;  mdata_q <= mdata_d;  mwren_q <= mwren_d;
        end
    end

    assign addr      = addr_q;
    assign mask_addr = maddr_q;
    assign mask_data = mdata_q;
    assign mask_wren = mwren_q;
    assign xMin      = xmin_q;
    assign xMax      = xmax_q;
    assign yMin      = ymin_q;
    assign yMax      = ymax_q;
    assign found     = found_q;
    assign done      = done_q;
endmodule
